// File: rtl/mp_icache_darb_pkg.sv
// Shared types and sizes for the icache data-array arbiter.
// Used by mp_icache_data_arbiter.
package mp_icache_darb_pkg;

    localparam int ADDR_WIDTH   = 4;
    localparam int DATA_WIDTH   = 256;
    localparam int NUM_WMASKS   = DATA_WIDTH / 8;
    localparam int STARVE_LIMIT = 4;

    typedef logic [DATA_WIDTH-1:0] line_t;
    typedef logic [NUM_WMASKS-1:0] mask_t;
    typedef logic [ADDR_WIDTH-1:0] set_t;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } darb_op_t;

endpackage

// File: rtl/mp_icache_data_arbiter.sv
// Single-port icache data SRAM arbiter: refill write vs fetch read.
// Define ICACHE_DARB_STARVE_EN to bound fetch starvation under refill.
module mp_icache_data_arbiter
    import mp_icache_darb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  refill_valid,
    input  logic [ADDR_WIDTH-1:0] refill_addr,
    input  logic [NUM_WMASKS-1:0] refill_wmask,
    input  logic [DATA_WIDTH-1:0] refill_wdata,
    output logic                  refill_ready,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    darb_op_t op;
    logic     force_fetch;
    logic     rd_pend_q;
    logic     rvalid_q;
    line_t    rdata_q;

`ifdef ICACHE_DARB_STARVE_EN
    logic [2:0] starve_cnt;
`endif

    // Grant decode and SRAM port drive; idle while reset is asserted
    always_comb begin
        op           = OP_IDLE;
        force_fetch  = 1'b0;
        fetch_ready  = 1'b0;
        refill_ready = 1'b0;
        sram_csb0    = 1'b1;
        sram_web0    = 1'b1;
        sram_wmask0  = '0;
        sram_addr0   = '0;
        sram_din0    = '0;
`ifdef ICACHE_DARB_STARVE_EN
        force_fetch = fetch_valid && (starve_cnt == 3'(STARVE_LIMIT));
`endif
        if (rst_n) begin
            if (force_fetch)
                op = OP_READ;
            else if (refill_valid)
                op = OP_WRITE;
            else if (fetch_valid)
                op = OP_READ;
        end
        unique case (op)
            OP_READ: begin
                fetch_ready = 1'b1;
                sram_csb0   = 1'b0;
                sram_addr0  = fetch_addr;
            end
            OP_WRITE: begin
                refill_ready = 1'b1;
                sram_csb0    = 1'b0;
                sram_web0    = 1'b0;
                sram_wmask0  = refill_wmask;
                sram_addr0   = refill_addr;
                sram_din0    = refill_wdata;
            end
            default: ;
        endcase
    end

    // Read pipeline: grant -> pending -> captured data with rvalid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
`ifdef ICACHE_DARB_STARVE_EN
            starve_cnt <= '0;
`endif
        end else begin
            rd_pend_q <= (op == OP_READ);
            rvalid_q  <= rd_pend_q;
            if (rd_pend_q)
                rdata_q <= sram_dout0;
`ifdef ICACHE_DARB_STARVE_EN
            if (!fetch_valid || fetch_ready)
                starve_cnt <= '0;
            else if (refill_valid)
                starve_cnt <= starve_cnt + 3'd1;
`endif
        end
    end

    assign fetch_rvalid = rvalid_q;
    assign fetch_rdata  = rdata_q;

endmodule
